ccip_intf_pipe: RTL and testbench
=================================

# ccip_intf_pipe

Parametrised CCI-P boundary staging block between the FIU-facing CCI-P port and the AFU core (for example, the BIST loopback engine).
- Generalises the fixed single-stage interface register:
  - independently configurable Rx and Tx pipeline depths;
  - a stretched, glitch-free AFU soft reset with Tx valid gating;
  - sticky and counted protocol-error capture;
  - optional request/response statistics counters.

## Interface
Parameters:
- RX_STAGES, default 1: FIU→AFU register stages, legal range 1..4.
- TX_STAGES, default 1: AFU→FIU register stages, legal range 1..4.
- RST_STRETCH, default 16: cycles afu_softReset stays high after the input reset is released, legal range 1..255.
- Any value outside its legal range is an elaboration-time error.

Ports:
- pClk  in  1  sole clock (400 MHz CCI-P clock).
- pck_cp2af_softReset  in  1  reset: synchronous, active-high.
- pck_cp2af_pwrState  in  2  FIU power state.
- pck_cp2af_error  in  1  FIU protocol error pulse.
- pck_cp2af_sRx  in  t_if_ccip_Rx  FIU Rx port.
- pck_af2cp_sTx  out  t_if_ccip_Tx  Tx to FIU.
- afu_softReset  out  1  stretched reset to the AFU core.
- afu_pwrState  out  2  pwrState delayed by RX_STAGES.
- afu_error_sticky  out  1  set by any sampled error.
- afu_error_cnt  out  16  saturating error count.
- afu_sRx  out  t_if_ccip_Rx  Rx to the AFU core.
- afu_sTx  in  t_if_ccip_Tx  AFU core Tx.
- stat_c0_req, stat_c1_req, stat_rx_rsp  out  32 each  present only with CCIP_INTF_PIPE_STATS_EN.

## Operation
Rx path:
- RX_STAGES-deep register chain carrying pck_cp2af_sRx and pck_cp2af_pwrState.
- While pck_cp2af_softReset is high, all Rx valid bits in every stage clear: c0.rspValid, c0.mmioRdValid, c0.mmioWrValid, c1.rspValid.
- The c0TxAlmFull and c1TxAlmFull bits are never masked.
- Payload fields are not reset.

Tx path:
- TX_STAGES-deep chain.
- At chain entry, c0.valid, c1.valid and c2.mmioRdValid are ANDed with !afu_softReset.
- Stage valid bits clear while pck_cp2af_softReset is high.

Reset FSM states:
- RST: input reset high. afu_softReset=1, counter loaded with RST_STRETCH-1.
- STRETCH: afu_softReset=1, counter decrements each cycle. Counter==0 → RUN.
- RUN: afu_softReset=0.
- Input reset high in any state → RST on the next edge. This includes reassertion mid-STRETCH, where the counter reloads.
- RST → STRETCH on the first edge that samples the input reset low.

Error capture:
- Error sampled high while not in RST → afu_error_sticky=1.
- Same condition → afu_error_cnt increments, saturating at 0xFFFF.
- Both error outputs clear only in RST.
- An error pulse coincident with input reset high is discarded.

## Timing
- Reset values: all Tx/Rx valid bits 0, afu_softReset 1, afu_error_sticky 0, afu_error_cnt 0, stats 0, FSM in RST.
- Rx latency is exactly RX_STAGES cycles; Tx latency is exactly TX_STAGES cycles; no bubbles and no back-pressure.
- afu_softReset rises on the first edge sampling input reset high.
- afu_softReset falls on edge RST_STRETCH, counted from the first edge sampling input reset low (that edge is edge 0).
- Tx requests issued by the AFU during STRETCH never reach the FIU.
- AlmFull arrives RX_STAGES cycles late and requests take TX_STAGES cycles to reach the FIU.
  - The AFU core must budget RX_STAGES+TX_STAGES extra in-flight requests against the FIU allowance.
  - The block does not compensate for this.
- Error outputs update one cycle after the sampled pulse.

## Configuration
- CCIP_INTF_PIPE_STATS_EN defined → three 32-bit counters:
  - stat_c0_req counts c0.valid at the Tx chain output.
  - stat_c1_req counts c1.valid at the Tx chain output.
  - stat_rx_rsp counts c0.rspValid|c1.rspValid at the Rx chain output; both in one cycle add 2.
- Counters wrap modulo 2^32 and clear while afu_softReset is high.
- Macro undefined → the ports and logic are absent; all other behaviour is identical.

## Test plan
- RX_STAGES=3, TX_STAGES=2, c0.rspValid pulse at cycle 100 → afu_sRx.c0.rspValid at 103. c1.valid pulse at 100 → pck_af2cp_sTx.c1.valid at 102, with payload intact.
- RST_STRETCH=16: input reset released, first low sample at edge 0 → afu_softReset=1 through edge 15, 0 from edge 16. AFU c0.valid held high during STRETCH → zero FIU requests.
- Input reset reasserted for one cycle at stretch edge 10 → FSM returns to RST. afu_softReset stays high continuously and falls 16 edges after the new release.
- 70000 error pulses in RUN → afu_error_sticky=1 and afu_error_cnt=0xFFFF. Error pulse coincident with reset → cnt remains 0.
- With STATS_EN: 5 c0 requests, 3 c1 requests, 2 cycles with dual rspValid → stat_c0_req=5, stat_c1_req=3, stat_rx_rsp=4. Reset → all 0.
- c0TxAlmFull toggled while input reset is high → it propagates to afu_sRx with RX_STAGES latency, unmasked.

Source files
------------

// File: rtl/ccip_intf_pipe.sv
// ccip_intf_pipe: CCI-P boundary staging between the FIU port and the AFU core.
// Latency: Rx path RX_STAGES cycles, Tx path TX_STAGES cycles. afu_softReset is held for RST_STRETCH cycles after the input reset is released.
// Backpressure: none. AlmFull is forwarded with RX_STAGES delay, so the AFU must budget RX_STAGES+TX_STAGES extra requests.
//
// Ports:
//   pClk                    sole clock
//   pck_cp2af_softReset     synchronous active-high reset from the FIU
//   pck_cp2af_pwrState/error/sRx   FIU -> block
//   pck_af2cp_sTx           block -> FIU
//   afu_softReset           stretched reset to the AFU core
//   afu_pwrState/afu_sRx    block -> AFU core, delayed by RX_STAGES
//   afu_error_sticky/cnt    captured FIU protocol errors
//   afu_sTx                 AFU core -> block
//   stat_c0_req/c1_req/rx_rsp  traffic counters, present only when the
//                              CCIP_INTF_PIPE_STATS_EN macro is defined

package ccip_if_pkg;
    typedef logic [511:0] t_ccip_clData;
    typedef logic [63:0]  t_ccip_mmioData;

    typedef struct packed {
        logic [27:0]  hdr;
        t_ccip_clData data;
        logic         rspValid;
        logic         mmioRdValid;
        logic         mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic [27:0] hdr;
        logic        rspValid;
    } t_if_ccip_c1_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
        t_if_ccip_c1_Rx c1;
    } t_if_ccip_Rx;

    typedef struct packed {
        logic [73:0] hdr;
        logic        valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        logic [79:0]  hdr;
        t_ccip_clData data;
        logic         valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        logic [8:0]     hdr;
        logic           mmioRdValid;
        t_ccip_mmioData data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;
endpackage

module ccip_intf_pipe
    import ccip_if_pkg::*;
#(
    parameter int RX_STAGES   = 1,
    parameter int TX_STAGES   = 1,
    parameter int RST_STRETCH = 16
) (
    input  logic        pClk,
    input  logic        pck_cp2af_softReset,
    input  logic [1:0]  pck_cp2af_pwrState,
    input  logic        pck_cp2af_error,
    input  t_if_ccip_Rx pck_cp2af_sRx,
    output t_if_ccip_Tx pck_af2cp_sTx,
    output logic        afu_softReset,
    output logic [1:0]  afu_pwrState,
    output logic        afu_error_sticky,
    output logic [15:0] afu_error_cnt,
`ifdef CCIP_INTF_PIPE_STATS_EN
    output logic [31:0] stat_c0_req,
    output logic [31:0] stat_c1_req,
    output logic [31:0] stat_rx_rsp,
`endif
    output t_if_ccip_Rx afu_sRx,
    input  t_if_ccip_Tx afu_sTx
);

    if (RX_STAGES < 1 || RX_STAGES > 4) begin : g_bad_rx_stages
        $error("ccip_intf_pipe: RX_STAGES must be in 1..4");
    end
    if (TX_STAGES < 1 || TX_STAGES > 4) begin : g_bad_tx_stages
        $error("ccip_intf_pipe: TX_STAGES must be in 1..4");
    end
    if (RST_STRETCH < 1 || RST_STRETCH > 255) begin : g_bad_rst_stretch
        $error("ccip_intf_pipe: RST_STRETCH must be in 1..255");
    end

    // ---------------------------------------------------------------- reset FSM
    typedef enum logic [1:0] {ST_RST, ST_STRETCH, ST_RUN} state_e;

    state_e     state_q, state_d;
    logic [7:0] stretch_cnt_q, stretch_cnt_d;
    logic       soft_rst_q, soft_rst_d;

    always_comb begin
        state_d       = state_q;
        stretch_cnt_d = stretch_cnt_q;
        case (state_q)
            ST_RST: begin
                stretch_cnt_d = 8'(RST_STRETCH - 1);
                state_d       = ST_STRETCH;
            end
            ST_STRETCH: begin
                if (stretch_cnt_q == 8'd0) begin
                    state_d = ST_RUN;
                end else begin
                    stretch_cnt_d = stretch_cnt_q - 8'd1;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_RST;
        endcase
        // Registered straight from the next state so the AFU sees a clean level.
        soft_rst_d = (state_d != ST_RUN);
    end

    always_ff @(posedge pClk) begin
        if (pck_cp2af_softReset) begin
            state_q       <= ST_RST;
            stretch_cnt_q <= 8'(RST_STRETCH - 1);
            soft_rst_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            stretch_cnt_q <= stretch_cnt_d;
            soft_rst_q    <= soft_rst_d;
        end
    end

    assign afu_softReset = soft_rst_q;

    // ---------------------------------------------------------------- error capture
    logic        err_take;
    logic        err_sticky_q, err_sticky_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_take     = pck_cp2af_error && (state_q != ST_RST);
        err_sticky_d = err_sticky_q | err_take;
        err_cnt_d    = err_cnt_q;
        if (err_take && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
        if (state_q == ST_RST) begin
            err_sticky_d = 1'b0;
            err_cnt_d    = 16'd0;
        end
    end

    always_ff @(posedge pClk) begin
        if (pck_cp2af_softReset) begin
            err_sticky_q <= 1'b0;
            err_cnt_q    <= 16'd0;
        end else begin
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign afu_error_sticky = err_sticky_q;
    assign afu_error_cnt    = err_cnt_q;

    // ---------------------------------------------------------------- Rx chain
    // Payload is left unreset; only valid strobes are cleared. AlmFull is
    // never masked so the AFU sees FIU flow control even during reset.
    t_if_ccip_Rx rx_pipe_q  [RX_STAGES];
    t_if_ccip_Rx rx_pipe_d  [RX_STAGES];
    logic [1:0]  pwr_pipe_q [RX_STAGES];
    logic [1:0]  pwr_pipe_d [RX_STAGES];

    always_comb begin
        rx_pipe_d[0]  = pck_cp2af_sRx;
        pwr_pipe_d[0] = pck_cp2af_pwrState;
        for (int i = 1; i < RX_STAGES; i++) begin
            rx_pipe_d[i]  = rx_pipe_q[i-1];
            pwr_pipe_d[i] = pwr_pipe_q[i-1];
        end
        if (pck_cp2af_softReset) begin
            for (int i = 0; i < RX_STAGES; i++) begin
                rx_pipe_d[i].c0.rspValid    = 1'b0;
                rx_pipe_d[i].c0.mmioRdValid = 1'b0;
                rx_pipe_d[i].c0.mmioWrValid = 1'b0;
                rx_pipe_d[i].c1.rspValid    = 1'b0;
            end
        end
    end

    always_ff @(posedge pClk) begin
        rx_pipe_q  <= rx_pipe_d;
        pwr_pipe_q <= pwr_pipe_d;
    end

    assign afu_sRx      = rx_pipe_q[RX_STAGES-1];
    assign afu_pwrState = pwr_pipe_q[RX_STAGES-1];

    // ---------------------------------------------------------------- Tx chain
    // Requests are gated at entry by the stretched reset so nothing issued
    // by an AFU that is still coming out of reset reaches the FIU.
    t_if_ccip_Tx tx_pipe_q [TX_STAGES];
    t_if_ccip_Tx tx_pipe_d [TX_STAGES];

    always_comb begin
        tx_pipe_d[0]                = afu_sTx;
        tx_pipe_d[0].c0.valid       = afu_sTx.c0.valid       & ~soft_rst_q;
        tx_pipe_d[0].c1.valid       = afu_sTx.c1.valid       & ~soft_rst_q;
        tx_pipe_d[0].c2.mmioRdValid = afu_sTx.c2.mmioRdValid & ~soft_rst_q;
        for (int i = 1; i < TX_STAGES; i++) begin
            tx_pipe_d[i] = tx_pipe_q[i-1];
        end
        if (pck_cp2af_softReset) begin
            for (int i = 0; i < TX_STAGES; i++) begin
                tx_pipe_d[i].c0.valid       = 1'b0;
                tx_pipe_d[i].c1.valid       = 1'b0;
                tx_pipe_d[i].c2.mmioRdValid = 1'b0;
            end
        end
    end

    always_ff @(posedge pClk) begin
        tx_pipe_q <= tx_pipe_d;
    end

    assign pck_af2cp_sTx = tx_pipe_q[TX_STAGES-1];

`ifdef CCIP_INTF_PIPE_STATS_EN
    // ---------------------------------------------------------------- statistics
    logic [31:0] stat_c0_q, stat_c0_d;
    logic [31:0] stat_c1_q, stat_c1_d;
    logic [31:0] stat_rsp_q, stat_rsp_d;

    always_comb begin
        stat_c0_d  = stat_c0_q  + 32'(pck_af2cp_sTx.c0.valid);
        stat_c1_d  = stat_c1_q  + 32'(pck_af2cp_sTx.c1.valid);
        stat_rsp_d = stat_rsp_q + 32'(afu_sRx.c0.rspValid) + 32'(afu_sRx.c1.rspValid);
        if (soft_rst_q) begin
            stat_c0_d  = 32'd0;
            stat_c1_d  = 32'd0;
            stat_rsp_d = 32'd0;
        end
    end

    always_ff @(posedge pClk) begin
        if (pck_cp2af_softReset) begin
            stat_c0_q  <= 32'd0;
            stat_c1_q  <= 32'd0;
            stat_rsp_q <= 32'd0;
        end else begin
            stat_c0_q  <= stat_c0_d;
            stat_c1_q  <= stat_c1_d;
            stat_rsp_q <= stat_rsp_d;
        end
    end

    assign stat_c0_req = stat_c0_q;
    assign stat_c1_req = stat_c1_q;
    assign stat_rx_rsp = stat_rsp_q;
`endif

endmodule

// File: tb/tb_ccip_intf_pipe.sv
// tb_ccip_intf_pipe: directed checks of ccip_intf_pipe with RX_STAGES=3, TX_STAGES=2, RST_STRETCH=16.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_ccip_intf_pipe;
    import ccip_if_pkg::*;

    localparam int RXS = 3;
    localparam int TXS = 2;
    localparam int RSS = 16;

    logic        pClk = 1'b0;
    logic        rst  = 1'b1;
    logic [1:0]  pwr  = 2'b00;
    logic        err  = 1'b0;
    t_if_ccip_Rx fiu_rx;
    t_if_ccip_Tx fiu_tx;
    logic        afu_softReset;
    logic [1:0]  afu_pwrState;
    logic        afu_error_sticky;
    logic [15:0] afu_error_cnt;
    t_if_ccip_Rx afu_sRx;
    t_if_ccip_Tx afu_sTx;
`ifdef CCIP_INTF_PIPE_STATS_EN
    logic [31:0] stat_c0_req, stat_c1_req, stat_rx_rsp;
`endif

    always #5 pClk = ~pClk;

    ccip_intf_pipe #(.RX_STAGES(RXS), .TX_STAGES(TXS), .RST_STRETCH(RSS)) dut (
        .pClk                (pClk),
        .pck_cp2af_softReset (rst),
        .pck_cp2af_pwrState  (pwr),
        .pck_cp2af_error     (err),
        .pck_cp2af_sRx       (fiu_rx),
        .pck_af2cp_sTx       (fiu_tx),
        .afu_softReset       (afu_softReset),
        .afu_pwrState        (afu_pwrState),
        .afu_error_sticky    (afu_error_sticky),
        .afu_error_cnt       (afu_error_cnt),
`ifdef CCIP_INTF_PIPE_STATS_EN
        .stat_c0_req         (stat_c0_req),
        .stat_c1_req         (stat_c1_req),
        .stat_rx_rsp         (stat_rx_rsp),
`endif
        .afu_sRx             (afu_sRx),
        .afu_sTx             (afu_sTx)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pClk);
        #1;
    endtask

    task automatic idle();
        fiu_rx  = '0;
        afu_sTx = '0;
        pwr     = 2'b00;
    endtask

    // rx bits: {alm0, alm1, rsp0, mmioRd, mmioWr, rsp1}; tx bits: {c0, c1, c2}
    typedef struct packed {
        logic       rst;
        logic [1:0] pwr;
        logic [5:0] rx;
        logic [2:0] tx;
        logic [5:0] e_rx;
        logic [2:0] e_tx;
        logic [1:0] e_pwr;
    } vec_t;

    function automatic logic [5:0] rx_bits(input t_if_ccip_Rx r);
        return {r.c0TxAlmFull, r.c1TxAlmFull, r.c0.rspValid, r.c0.mmioRdValid,
                r.c0.mmioWrValid, r.c1.rspValid};
    endfunction

    function automatic logic [2:0] tx_bits(input t_if_ccip_Tx t);
        return {t.c0.valid, t.c1.valid, t.c2.mmioRdValid};
    endfunction

    vec_t vecs [7];

    initial begin
        logic [27:0]  rx_hdr0, rx_hdr1;
        logic [511:0] rx_data, tx_data;
        logic [73:0]  tx_hdr0;
        logic [79:0]  tx_hdr1;
        logic [63:0]  tx_mmio;
        logic [11:0]  pat;
        logic [11:0]  hist;
        int           seen;

        vecs[0] = '{rst:1'b0, pwr:2'b01, rx:6'b001000, tx:3'b000, e_rx:6'b001000, e_tx:3'b000, e_pwr:2'b01};
        vecs[1] = '{rst:1'b0, pwr:2'b10, rx:6'b000110, tx:3'b100, e_rx:6'b000110, e_tx:3'b100, e_pwr:2'b10};
        vecs[2] = '{rst:1'b0, pwr:2'b11, rx:6'b010001, tx:3'b010, e_rx:6'b010001, e_tx:3'b010, e_pwr:2'b11};
        vecs[3] = '{rst:1'b0, pwr:2'b11, rx:6'b111111, tx:3'b111, e_rx:6'b111111, e_tx:3'b111, e_pwr:2'b11};
        vecs[4] = '{rst:1'b0, pwr:2'b00, rx:6'b000000, tx:3'b000, e_rx:6'b000000, e_tx:3'b000, e_pwr:2'b00};
        vecs[5] = '{rst:1'b0, pwr:2'b01, rx:6'b100000, tx:3'b111, e_rx:6'b100000, e_tx:3'b111, e_pwr:2'b01};
        // Under input reset: valid strobes dropped, AlmFull and pwrState pass.
        vecs[6] = '{rst:1'b1, pwr:2'b10, rx:6'b101001, tx:3'b111, e_rx:6'b100000, e_tx:3'b000, e_pwr:2'b10};

        idle();

        // ---- reset state
        rst = 1'b1;
        repeat (4) tick();
        chk("rst_softReset", afu_softReset, 1'b1);
        chk("rst_rx_valid", rx_bits(afu_sRx), 6'b0);
        chk("rst_tx_valid", tx_bits(fiu_tx), 3'b0);
        chk("rst_err_sticky", afu_error_sticky, 1'b0);
        chk("rst_err_cnt", afu_error_cnt, 16'd0);
`ifdef CCIP_INTF_PIPE_STATS_EN
        chk("rst_stats", {stat_c0_req, stat_c1_req, stat_rx_rsp}, 96'd0);
`endif

        // ---- stretch with AFU c0 request held high: nothing reaches the FIU
        afu_sTx.c0.valid = 1'b1;
        afu_sTx.c0.hdr   = 74'h155;
        rst  = 1'b0;
        seen = 0;
        for (int e = 0; e <= RSS; e++) begin
            tick();
            if (fiu_tx.c0.valid) seen++;
            chk($sformatf("stretch_softReset_e%0d", e), afu_softReset, (e < RSS) ? 1'b1 : 1'b0);
        end
        afu_sTx.c0.valid = 1'b0;
        repeat (TXS + 1) begin
            tick();
            if (fiu_tx.c0.valid) seen++;
        end
        chk("stretch_fiu_c0_reqs", seen, 0);

        // ---- directed vector table
        for (int v = 0; v < 7; v++) begin
            rx_hdr0 = 28'($urandom());
            rx_hdr1 = 28'($urandom());
            rx_data = {16{$urandom()}};
            tx_data = {16{$urandom()}};
            tx_hdr0 = {10'($urandom()), $urandom(), $urandom()};
            tx_hdr1 = {16'($urandom()), $urandom(), $urandom()};
            tx_mmio = {$urandom(), $urandom()};
            rst = vecs[v].rst;
            pwr = vecs[v].pwr;
            {fiu_rx.c0TxAlmFull, fiu_rx.c1TxAlmFull, fiu_rx.c0.rspValid, fiu_rx.c0.mmioRdValid,
             fiu_rx.c0.mmioWrValid, fiu_rx.c1.rspValid} = vecs[v].rx;
            fiu_rx.c0.hdr  = rx_hdr0;
            fiu_rx.c0.data = rx_data;
            fiu_rx.c1.hdr  = rx_hdr1;
            {afu_sTx.c0.valid, afu_sTx.c1.valid, afu_sTx.c2.mmioRdValid} = vecs[v].tx;
            afu_sTx.c0.hdr  = tx_hdr0;
            afu_sTx.c1.hdr  = tx_hdr1;
            afu_sTx.c1.data = tx_data;
            afu_sTx.c2.data = tx_mmio;
            for (int k = 1; k <= 4; k++) begin
                tick();
                if (k == 1) idle();
                if (k == RXS - 1)
                    chk($sformatf("v%0d_rx_early", v), rx_bits(afu_sRx), 6'b0);
                if (k == RXS) begin
                    chk($sformatf("v%0d_rx_valid", v), rx_bits(afu_sRx), vecs[v].e_rx);
                    chk($sformatf("v%0d_pwr", v), afu_pwrState, vecs[v].e_pwr);
                    chk($sformatf("v%0d_rx_payload", v),
                        {afu_sRx.c0.hdr, afu_sRx.c1.hdr, afu_sRx.c0.data[455:0]},
                        {rx_hdr0, rx_hdr1, rx_data[455:0]});
                end
                if (k == TXS - 1)
                    chk($sformatf("v%0d_tx_early", v), tx_bits(fiu_tx), 3'b0);
                if (k == TXS) begin
                    chk($sformatf("v%0d_tx_valid", v), tx_bits(fiu_tx), vecs[v].e_tx);
                    chk($sformatf("v%0d_tx_c1_data", v), fiu_tx.c1.data, tx_data);
                    chk($sformatf("v%0d_tx_hdrs", v),
                        {fiu_tx.c0.hdr, fiu_tx.c1.hdr, fiu_tx.c2.data},
                        {tx_hdr0, tx_hdr1, tx_mmio});
                end
            end
        end

        // ---- reset reasserted mid-stretch (input reset is still high here)
        rst = 1'b0;
        for (int e = 0; e <= 10; e++) begin
            tick();
            chk($sformatf("restretch_a_e%0d", e), afu_softReset, 1'b1);
        end
        rst = 1'b1;
        tick();
        chk("restretch_in_rst", afu_softReset, 1'b1);
        rst = 1'b0;
        for (int e = 0; e <= RSS; e++) begin
            tick();
            chk($sformatf("restretch_b_e%0d", e), afu_softReset, (e < RSS) ? 1'b1 : 1'b0);
        end

        // ---- error capture and saturation
        chk("err_cnt_before", afu_error_cnt, 16'd0);
        err = 1'b1;
        tick();
        chk("err_cnt_first", afu_error_cnt, 16'd1);
        chk("err_sticky_first", afu_error_sticky, 1'b1);
        repeat (69999) tick();
        err = 1'b0;
        tick();
        chk("err_cnt_sat", afu_error_cnt, 16'hFFFF);
        chk("err_sticky_sat", afu_error_sticky, 1'b1);
        rst = 1'b1;
        err = 1'b1;
        repeat (3) tick();
        chk("err_cnt_in_rst", afu_error_cnt, 16'd0);
        chk("err_sticky_in_rst", afu_error_sticky, 1'b0);
        err = 1'b0;
        rst = 1'b0;
        repeat (RSS + 1) tick();
        chk("run_again", afu_softReset, 1'b0);
        chk("err_cnt_after_rst", afu_error_cnt, 16'd0);

`ifdef CCIP_INTF_PIPE_STATS_EN
        // ---- statistics: 5 c0, 3 c1, 2 dual-response cycles
        chk("stat_start", {stat_c0_req, stat_c1_req, stat_rx_rsp}, 96'd0);
        for (int i = 0; i < 5; i++) begin
            afu_sTx.c0.valid   = 1'b1;
            afu_sTx.c1.valid   = (i < 3);
            fiu_rx.c0.rspValid = (i < 2);
            fiu_rx.c1.rspValid = (i < 2);
            tick();
        end
        idle();
        repeat (6) tick();
        chk("stat_c0_req", stat_c0_req, 32'd5);
        chk("stat_c1_req", stat_c1_req, 32'd3);
        chk("stat_rx_rsp", stat_rx_rsp, 32'd4);
        rst = 1'b1;
        repeat (2) tick();
        chk("stat_cleared", {stat_c0_req, stat_c1_req, stat_rx_rsp}, 96'd0);
`endif

        // ---- AlmFull propagates unmasked while input reset is high
        rst  = 1'b1;
        pat  = 12'b1011_0011_1010;
        hist = '0;
        for (int i = 0; i < 12; i++) begin
            fiu_rx.c0TxAlmFull = pat[i];
            fiu_rx.c0.rspValid = 1'b1;
            hist[i] = pat[i];
            tick();
            if (i >= RXS - 1) begin
                chk($sformatf("almfull_i%0d", i), afu_sRx.c0TxAlmFull, hist[i-RXS+1]);
                chk($sformatf("almfull_rsp_masked_i%0d", i), afu_sRx.c0.rspValid, 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
